pipeline_ctrl: RTL
==================

# pipeline_ctrl

Pipeline control unit for the five-stage MIPS core. Merges stall requests from ID, EX and MEM into the 6-bit `stall` vector consumed by `pc_reg` and every pipeline register. Converts committed exceptions into a one-cycle `flush` plus the `new_pc` redirect target. Tracks stall activity with a consecutive-stall watchdog and a free-running stall-cycle counter.

## Interface
- `EXC_VECTOR`, 32'h00000020, redirect target for every exception except ERET
- `STALL_TIMEOUT`, 16'd1024, consecutive stalled cycles that set `stall_timeout`
- `clk`  in  1  core clock
- `rst`  in  1  reset; one clock; reset is synchronous and active-high (`RstEnable` = 1'b1)
- `stallreq_from_id`  in  1  ID needs a bubble (load-use hazard)
- `stallreq_from_ex`  in  1  EX multi-cycle op in progress (div, madd/msub)
- `stallreq_from_mem`  in  1  MEM waiting on data bus
- `excepttype_i`  in  32  exception type committed in MEM; 0 = none
- `cp0_epc_i`  in  32  current EPC from CP0
- `stall`  out  6  [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB; 1 = hold
- `flush`  out  1  clear all pipeline registers, load `new_pc`
- `new_pc`  out  32  redirect target, valid only while `flush`=1
- `stall_timeout`  out  1  sticky watchdog flag
- `stall_cycles`  out  32  total cycles with `stall`≠0

## Operation
- FSM states: RUN, STALL, FLUSH (registered).
- Priority within a cycle: exception > MEM > EX > ID.
- Exception (`excepttype_i`≠0, state≠FLUSH): `flush`=1, `stall`=6'b000000. `new_pc` = `cp0_epc_i` for ERET (32'h0000000e), else `EXC_VECTOR`. Next state FLUSH.
- FLUSH (exactly one cycle): `excepttype_i` and all stall requests ignored. `flush`=0, `stall`=0. Next state RUN.
- Stall encoding, no exception:
  - MEM → 6'b011111
  - EX → 6'b001111
  - ID → 6'b000111
  - none → 6'b000000
- Next state: STALL if `stall`≠0, else RUN.
- Watchdog:
  - 16-bit `stall_run` increments each cycle with `stall`≠0 and saturates at 16'hFFFF.
  - Clears to 0 on any cycle with `stall`=0, including FLUSH and exception cycles.
  - `stall_timeout` is set at the edge where `stall_run` reaches `STALL_TIMEOUT`. It stays set until `rst`.
- `stall_cycles` increments on each cycle with `stall`≠0 and wraps modulo 2^32.
- Requesters hold their request until done. The unit stores no request.

## Timing
- `stall`, `flush`, `new_pc` are combinational from inputs and state (zero latency). `pc_reg` and the pipeline registers sample them at the same edge.
- While `rst`=1: `stall`=0, `flush`=0, `new_pc`=0 (gated).
- At the first edge with `rst`=1: state=RUN, `stall_run`=0, `stall_timeout`=0, `stall_cycles`=0.
- Reset mid-stall or mid-FLUSH: everything is discarded. RUN applies at the next edge.
- Exception and stall request in the same cycle: exception wins, and the cycle does not count as stalled.
- Back-to-back exceptions: the second is ignored during FLUSH. If it is still asserted afterwards, it is taken in the cycle after FLUSH.
- Watchdog boundary: with `STALL_TIMEOUT`=N, N consecutive stalled cycles drive `stall_timeout` high in cycle N+1.

## Structure
- The following belong in `defines.v`:
  - stall encodings `StallNone`/`StallId`/`StallEx`/`StallMem`
  - exception codes: interrupt 0x1, syscall 0x8, invalid inst 0xa, trap 0xd, overflow 0xc, ERET 0xe
  - `ExcNone` = 32'h0
  - `RstEnable`
- Include a sub-module `stall_watchdog`, which holds `stall_run`, `stall_timeout` and `stall_cycles`. Its inputs are `clk`, `rst` and `stalled` = |`stall`.
- The FSM and priority encoding live in the top module.

## Test plan
- `rst`=1 for 2 cycles, then idle → `stall`=0, `flush`=0, `stall_cycles`=0, `stall_timeout`=0, state RUN.
- `stallreq_from_ex` high for 3 cycles with `stallreq_from_id` also high → `stall`=6'b001111 for 3 cycles, `stall_cycles`=3, then 0.
- `excepttype_i`=0xc with `stallreq_from_mem`=1 in the same cycle → `flush`=1, `stall`=0, `new_pc`=32'h20. Next cycle `flush`=0 with requests ignored. `stall_cycles` unchanged.
- `excepttype_i`=0xe, `cp0_epc_i`=32'h00400104 → `new_pc`=32'h00400104 with `flush`=1. A second ERET held an extra cycle → ignored in FLUSH, taken the cycle after.
- `STALL_TIMEOUT`=4, `stallreq_from_mem` high for 4 cycles → `stall_timeout`=1 in cycle 5 and stays high after the request drops. A run of 3 cycles alone → no timeout.
- Assert `rst` during a MEM stall → outputs 0 immediately, `stall_cycles`=0 after the edge, normal stalling after release.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared constants and types for the pipeline control unit: stall vector
//   encodings, committed exception codes, reset polarity and FSM states.
package pipeline_ctrl_pkg;

  localparam logic RstEnable = 1'b1;

  // stall bit order: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB, 1 = hold
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;

  localparam logic [31:0] ExcNone    = 32'h0000_0000;
  localparam logic [31:0] ExcInt     = 32'h0000_0001;
  localparam logic [31:0] ExcSyscall = 32'h0000_0008;
  localparam logic [31:0] ExcInvInst = 32'h0000_000a;
  localparam logic [31:0] ExcOv      = 32'h0000_000c;
  localparam logic [31:0] ExcTrap    = 32'h0000_000d;
  localparam logic [31:0] ExcEret    = 32'h0000_000e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
//   Bundle between the pipeline stages (master) and the control unit (slave).
//   Requests are level signals: a requester holds stallreq_* / excepttype_i
//   until the condition is resolved; the control unit answers in the same
//   cycle through stall/flush/new_pc and never latches a request.
//   master: drives stallreq_from_id/ex/mem, excepttype_i, cp0_epc_i
//   slave : drives stall, flush, new_pc, stall_timeout, stall_cycles
interface pipeline_ctrl_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;

  modport master (
    output stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_timeout, stall_cycles
  );

  modport slave (
    input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, stall_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// stall_watchdog
//   Counts stall activity.
//   clk, rst       : core clock, synchronous active-high reset
//   stalled        : 1 when any stall bit is set this cycle
//   stall_timeout  : sticky, set once TIMEOUT consecutive stalled cycles occur
//   stall_cycles   : free-running count of stalled cycles (wraps)
module stall_watchdog
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stalled,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);

  logic [15:0] stall_run;
  logic [15:0] run_nxt;

  // saturating increment of the consecutive-stall run length
  assign run_nxt = (stall_run == 16'hFFFF) ? stall_run : stall_run + 16'd1;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      stall_run     <= '0;
      stall_timeout <= 1'b0;
      stall_cycles  <= '0;
    end else if (stalled) begin
      stall_run    <= run_nxt;
      stall_cycles <= stall_cycles + 32'd1;
      // flag rises on the same edge the run length reaches the limit
      if (run_nxt == TIMEOUT) stall_timeout <= 1'b1;
    end else begin
      stall_run <= '0;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Merges ID/EX/MEM stall requests into the 6-bit stall vector and turns a
//   committed exception into a one-cycle flush with a redirect target.
//   clk, rst  : core clock, synchronous active-high reset
//   bus       : pipeline_ctrl_if.slave (requests in, stall/flush/new_pc and
//               watchdog status out)
//   dbg_state : current FSM state
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter logic [15:0] STALL_TIMEOUT = 16'd1024
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_ctrl_if.slave       bus,
  output state_t               dbg_state
);

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  stall_c;
  logic        flush_c;
  logic [31:0] new_pc_c;

  // Outputs are combinational so pc_reg and the stage registers act on them
  // at the same edge. Priority: exception > MEM > EX > ID.
  always_comb begin
    stall_c   = StallNone;
    flush_c   = 1'b0;
    new_pc_c  = '0;
    state_nxt = RUN;
    if (rst == RstEnable) begin
      state_nxt = RUN;
    end else if (state == FLUSH) begin
      // the flush cycle ignores every request; a held exception is retaken next
      state_nxt = RUN;
    end else if (bus.excepttype_i != ExcNone) begin
      flush_c   = 1'b1;
      new_pc_c  = (bus.excepttype_i == ExcEret) ? bus.cp0_epc_i : EXC_VECTOR;
      state_nxt = FLUSH;
    end else begin
      if (bus.stallreq_from_mem)     stall_c = StallMem;
      else if (bus.stallreq_from_ex) stall_c = StallEx;
      else if (bus.stallreq_from_id) stall_c = StallId;
      state_nxt = (stall_c != StallNone) ? STALL : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) state <= RUN;
    else                  state <= state_nxt;
  end

  assign bus.stall  = stall_c;
  assign bus.flush  = flush_c;
  assign bus.new_pc = new_pc_c;
  assign dbg_state  = state;

  stall_watchdog #(
    .TIMEOUT (STALL_TIMEOUT)
  ) u_watchdog (
    .clk           (clk),
    .rst           (rst),
    .stalled       (|stall_c),
    .stall_timeout (bus.stall_timeout),
    .stall_cycles  (bus.stall_cycles)
  );

endmodule
